// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port data RAM between the processor load/store path
//   (port 0) and the loader/debug path (port 1). One access is granted at a
//   time. Writes complete in the grant cycle. Reads hold off further grants
//   until the RAM data has been captured and returned with a valid strobe.
//
// Ports
//   clk, reset            system clock (rising edge), synchronous active-high reset
//   req0/we0/addr0/wdata0 port 0 request, write flag, address, write data
//   gnt0, rvalid0         port 0 grant pulse, read-data-valid pulse
//   req1/we1/addr1/wdata1 port 1 request, write flag, address, write data
//   gnt1, rvalid1         port 1 grant pulse, read-data-valid pulse
//   rdata                 registered read data shared by both ports
//   mem_addr/mem_din      RAM address and write data
//   mem_we                RAM write enable
//   mem_dout              RAM read data, valid RD_LAT cycles after the address edge
//   busy                  high while a read is outstanding
module mem_port_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic {IDLE, RDWAIT} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  state_t        state;
  state_t        state_next;
  logic [1:0]    wait_cnt;
  logic          owner;
  logic          favour;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_din;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic [DW-1:0] rdata_q;
  logic          grant_any;
  logic          win1;

  // Arbitration and RAM drive. With no grant the RAM sees the held address
  // and data of the last granted access, which also keeps the read address
  // stable for the whole read latency. 'favour' names the port that wins the
  // next tie in round-robin mode. Grants are suppressed while reset is high
  // so a request present during reset cannot write the RAM.
  always_comb begin
    state_next = state;
    grant_any  = 1'b0;
    win1       = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = hold_addr;
    mem_din    = hold_din;
    case (state)
      IDLE: begin
        if (!reset && (req0 || req1)) begin
          grant_any = 1'b1;
          if (!req0)
            win1 = 1'b1;
          else if (req1 && (PRIO_MODE == 0) && favour)
            win1 = 1'b1;
          gnt0     = ~win1;
          gnt1     = win1;
          mem_addr = win1 ? addr1  : addr0;
          mem_din  = win1 ? wdata1 : wdata0;
          mem_we   = win1 ? we1    : we0;
          if (!mem_we)
            state_next = RDWAIT;
        end
      end
      RDWAIT: begin
        if (wait_cnt == 2'd1)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, hold registers and the round-robin pointer. The counter is
  // loaded with the read latency on a read grant and counts the RDWAIT
  // cycles; the cycle in which it reads 1 is the one where mem_dout is
  // valid, so rdata is captured then and the owner's rvalid fires in the
  // following cycle, which is already back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      owner     <= 1'b0;
      favour    <= 1'b0;
      hold_addr <= '0;
      hold_din  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state     <= state_next;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      if (grant_any) begin
        hold_addr <= mem_addr;
        hold_din  <= mem_din;
        favour    <= ~win1;
        if (!mem_we) begin
          owner    <= win1;
          wait_cnt <= LAT_INIT;
        end
      end
      if (state == RDWAIT) begin
        wait_cnt <= wait_cnt - 2'd1;
        if (wait_cnt == 2'd1) begin
          rdata_q   <= mem_dout;
          rvalid0_q <= ~owner;
          rvalid1_q <= owner;
        end
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiter instances run side by side: instance 0 with RD_LAT=1 and
//   round-robin, instance 1 with RD_LAT=2 and fixed priority. Each has its
//   own RAM model. A cycle-numbered reference model predicts every output.
module tb_mem_port_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset;

  logic        req0   [N];
  logic        we0    [N];
  logic [4:0]  addr0  [N];
  logic [15:0] wdata0 [N];
  logic        req1   [N];
  logic        we1    [N];
  logic [4:0]  addr1  [N];
  logic [15:0] wdata1 [N];
  logic        gnt0   [N];
  logic        gnt1   [N];
  logic        rvalid0[N];
  logic        rvalid1[N];
  logic [15:0] rdata  [N];
  logic [4:0]  mem_addr[N];
  logic [15:0] mem_din[N];
  logic        mem_we [N];
  logic        busy   [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state, indexed by instance
  logic [15:0] m_mem    [N][32];
  int          m_idle_at[N];
  int          m_rv_at  [N];
  int          m_rv_port[N];
  int          m_last   [N];
  logic [15:0] m_rv_data[N];
  logic [15:0] m_rdata  [N];
  logic [4:0]  m_hold_a [N];
  logic [15:0] m_hold_d [N];
  logic        e_gnt0   [N];
  logic        e_gnt1   [N];

  // Random requester state
  bit          pend[N][2];
  bit          s_we[N][2];
  logic [4:0]  s_a [N][2];
  logic [15:0] s_d [N][2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_inst
    logic [15:0] ram [32] = '{default: 16'h0000};
    logic [15:0] pipe1;
    logic [15:0] pipe2;
    logic [15:0] dout;

    // RAM with RD_LAT cycles of read latency
    always @(posedge clk) begin
      if (mem_we[g]) ram[mem_addr[g]] <= mem_din[g];
      pipe1 <= ram[mem_addr[g]];
      pipe2 <= pipe1;
    end
    assign dout = (g == 0) ? pipe1 : pipe2;

    mem_port_arbiter #(.AW(5), .DW(16), .RD_LAT(g + 1), .PRIO_MODE(g)) dut (
      .clk(clk), .reset(reset),
      .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
      .gnt0(gnt0[g]), .rvalid0(rvalid0[g]),
      .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
      .gnt1(gnt1[g]), .rvalid1(rvalid1[g]),
      .rdata(rdata[g]), .mem_addr(mem_addr[g]), .mem_din(mem_din[g]),
      .mem_we(mem_we[g]), .mem_dout(dout), .busy(busy[g])
    );
  end

  task automatic checkOutput(input string tag, input int i,
                             input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s inst%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_idle_at[i] = 0;
      m_rv_at[i]   = -1;
      m_rv_port[i] = 0;
      m_last[i]    = 1;
      m_rdata[i]   = 16'h0;
      m_hold_a[i]  = 5'h0;
      m_hold_d[i]  = 16'h0;
      pend[i][0]   = 1'b0;
      pend[i][1]   = 1'b0;
    end
  endtask

  // Predict and compare all outputs of instance i for the current cycle,
  // then account for the access that the coming edge completes.
  task automatic modelStep(input int i);
    int          lat;
    bit          prio;
    bit          idle;
    int          w;
    logic        ew;
    logic [4:0]  ea;
    logic [15:0] ed;
    lat  = i + 1;
    prio = (i == 1);
    idle = (cyc >= m_idle_at[i]);
    w    = -1;
    if (cyc == m_rv_at[i]) m_rdata[i] = m_rv_data[i];
    if (idle && (req0[i] || req1[i])) begin
      if (req0[i] && req1[i]) w = prio ? 0 : ((m_last[i] == 0) ? 1 : 0);
      else                    w = req0[i] ? 0 : 1;
    end
    e_gnt0[i] = (w == 0);
    e_gnt1[i] = (w == 1);
    if (w < 0) begin
      ew = 1'b0; ea = m_hold_a[i]; ed = m_hold_d[i];
    end else if (w == 0) begin
      ew = we0[i]; ea = addr0[i]; ed = wdata0[i];
    end else begin
      ew = we1[i]; ea = addr1[i]; ed = wdata1[i];
    end
    checkOutput("gnt0",     i, 32'(gnt0[i]),     32'(e_gnt0[i]));
    checkOutput("gnt1",     i, 32'(gnt1[i]),     32'(e_gnt1[i]));
    checkOutput("rvalid0",  i, 32'(rvalid0[i]),  32'(cyc == m_rv_at[i] && m_rv_port[i] == 0));
    checkOutput("rvalid1",  i, 32'(rvalid1[i]),  32'(cyc == m_rv_at[i] && m_rv_port[i] == 1));
    checkOutput("rdata",    i, 32'(rdata[i]),    32'(m_rdata[i]));
    checkOutput("busy",     i, 32'(busy[i]),     32'(!idle));
    checkOutput("mem_we",   i, 32'(mem_we[i]),   32'(ew));
    checkOutput("mem_addr", i, 32'(mem_addr[i]), 32'(ea));
    checkOutput("mem_din",  i, 32'(mem_din[i]),  32'(ed));
    if (w >= 0) begin
      m_last[i]   = w;
      m_hold_a[i] = ea;
      m_hold_d[i] = ed;
      if (ew) begin
        m_mem[i][ea] = ed;
      end else begin
        m_idle_at[i] = cyc + lat + 1;
        m_rv_at[i]   = cyc + lat + 1;
        m_rv_port[i] = w;
        m_rv_data[i] = m_mem[i][ea];
      end
    end
  endtask

  task automatic setReq(input int p, input logic r, input logic w,
                        input logic [4:0] a, input logic [15:0] d);
    for (int i = 0; i < N; i++) begin
      if (p == 0) begin
        req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d;
      end else begin
        req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d;
      end
    end
  endtask

  task automatic idleReq();
    setReq(0, 1'b0, 1'b0, 5'd0, 16'h0);
    setReq(1, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  task automatic atNegedge();
    @(negedge clk);
    for (int i = 0; i < N; i++) modelStep(i);
  endtask

  task automatic toPosedge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runCycle();
    atNegedge();
    toPosedge();
  endtask

  // Random requesters: each holds its request stable until granted,
  // occasionally gives up on a pending request.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[i][p] && $urandom_range(0, 15) == 0) begin
          pend[i][p] = 1'b0;
        end else if (!pend[i][p] && $urandom_range(0, 1) == 1) begin
          pend[i][p] = 1'b1;
          s_we[i][p] = ($urandom_range(0, 2) != 0);
          s_a[i][p]  = 5'($urandom_range(0, 31));
          s_d[i][p]  = 16'($urandom);
        end
      end
      req0[i] = pend[i][0]; we0[i] = s_we[i][0]; addr0[i] = s_a[i][0]; wdata0[i] = s_d[i][0];
      req1[i] = pend[i][1]; we1[i] = s_we[i][1]; addr1[i] = s_a[i][1]; wdata1[i] = s_d[i][1];
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 32; a++) m_mem[i][a] = 16'h0;
    reset = 1'b1;
    idleReq();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();

    // Port 1 write 0x1234 to addr 5
    $display("[TB] single write from port 1");
    setReq(1, 1'b1, 1'b1, 5'd5, 16'h1234);
    atNegedge();
    for (int i = 0; i < N; i++) begin
      checkOutput("t1_gnt1",   i, 32'(gnt1[i]),     32'd1);
      checkOutput("t1_we",     i, 32'(mem_we[i]),   32'd1);
      checkOutput("t1_addr",   i, 32'(mem_addr[i]), 32'd5);
      checkOutput("t1_din",    i, 32'(mem_din[i]),  32'h1234);
      checkOutput("t1_busy",   i, 32'(busy[i]),     32'd0);
    end
    toPosedge();
    idleReq();

    // Port 0 reads addr 5
    $display("[TB] read back from port 0");
    setReq(0, 1'b1, 1'b0, 5'd5, 16'h0);
    atNegedge();
    for (int i = 0; i < N; i++) checkOutput("t2_gnt0", i, 32'(gnt0[i]), 32'd1);
    toPosedge();
    idleReq();
    atNegedge();
    for (int i = 0; i < N; i++) checkOutput("t2_busy", i, 32'(busy[i]), 32'd1);
    toPosedge();
    atNegedge();
    checkOutput("t2_rvalid0", 0, 32'(rvalid0[0]), 32'd1);
    checkOutput("t2_rvalid1", 0, 32'(rvalid1[0]), 32'd0);
    checkOutput("t2_rdata",   0, 32'(rdata[0]),   32'h1234);
    checkOutput("t2_busy2",   1, 32'(busy[1]),    32'd1);
    toPosedge();
    atNegedge();
    checkOutput("t2_rvalid0", 1, 32'(rvalid0[1]), 32'd1);
    checkOutput("t2_rdata",   1, 32'(rdata[1]),   32'h1234);
    toPosedge();

    // Continuous tie of write requests
    $display("[TB] continuous tie");
    setReq(0, 1'b1, 1'b1, 5'd10, 16'hA000);
    setReq(1, 1'b1, 1'b1, 5'd11, 16'hB000);
    for (int k = 0; k < 6; k++) begin
      atNegedge();
      checkOutput("t3_rr_gnt1", 0, 32'(gnt1[0]), 32'(k % 2 == 0));
      checkOutput("t3_rr_gnt0", 0, 32'(gnt0[0]), 32'(k % 2 == 1));
      checkOutput("t3_fp_gnt0", 1, 32'(gnt0[1]), 32'd1);
      checkOutput("t3_fp_gnt1", 1, 32'(gnt1[1]), 32'd0);
      toPosedge();
    end
    idleReq();
    runCycle();

    // Port 1 write waits behind an outstanding port 0 read
    $display("[TB] write blocked by outstanding read");
    setReq(0, 1'b1, 1'b0, 5'd10, 16'h0);
    runCycle();
    setReq(0, 1'b0, 1'b0, 5'd0, 16'h0);
    setReq(1, 1'b1, 1'b1, 5'd20, 16'h5555);
    atNegedge();
    checkOutput("t4_gnt1_t1", 1, 32'(gnt1[1]), 32'd0);
    toPosedge();
    atNegedge();
    checkOutput("t4_gnt1_t2", 1, 32'(gnt1[1]), 32'd0);
    toPosedge();
    atNegedge();
    checkOutput("t4_gnt1_t3", 1, 32'(gnt1[1]),    32'd1);
    checkOutput("t4_rvalid0", 1, 32'(rvalid0[1]), 32'd1);
    checkOutput("t4_rdata",   1, 32'(rdata[1]),   32'hA000);
    toPosedge();
    idleReq();
    repeat (3) runCycle();

    // Reset in the middle of a read
    $display("[TB] reset during read");
    setReq(0, 1'b1, 1'b0, 5'd20, 16'h0);
    runCycle();
    idleReq();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    modelReset();
    atNegedge();
    for (int i = 0; i < N; i++) begin
      checkOutput("t5_rdata",   i, 32'(rdata[i]),   32'h0);
      checkOutput("t5_busy",    i, 32'(busy[i]),    32'd0);
      checkOutput("t5_we",      i, 32'(mem_we[i]),  32'd0);
      checkOutput("t5_rvalid0", i, 32'(rvalid0[i]), 32'd0);
    end
    toPosedge();
    setReq(0, 1'b1, 1'b1, 5'd3, 16'h0003);
    setReq(1, 1'b1, 1'b1, 5'd4, 16'h0004);
    atNegedge();
    for (int i = 0; i < N; i++) begin
      checkOutput("t5_tie_gnt0", i, 32'(gnt0[i]), 32'd1);
      checkOutput("t5_tie_gnt1", i, 32'(gnt1[i]), 32'd0);
    end
    toPosedge();
    idleReq();
    repeat (3) runCycle();

    // Back-to-back writes at the address extremes
    $display("[TB] back-to-back writes at 31 and 0");
    setReq(0, 1'b1, 1'b1, 5'd31, 16'hBEEF);
    atNegedge();
    for (int i = 0; i < N; i++) begin
      checkOutput("t6_gnt0_a", i, 32'(gnt0[i]),     32'd1);
      checkOutput("t6_addr31", i, 32'(mem_addr[i]), 32'd31);
    end
    toPosedge();
    setReq(0, 1'b1, 1'b1, 5'd0, 16'hCAFE);
    atNegedge();
    for (int i = 0; i < N; i++) begin
      checkOutput("t6_gnt0_b", i, 32'(gnt0[i]),     32'd1);
      checkOutput("t6_addr0",  i, 32'(mem_addr[i]), 32'd0);
      checkOutput("t6_din",    i, 32'(mem_din[i]),  32'hCAFE);
    end
    toPosedge();
    setReq(0, 1'b1, 1'b0, 5'd31, 16'h0);
    runCycle();
    idleReq();
    repeat (3) runCycle();

    // Random traffic against the reference model
    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      applyStimulus();
      atNegedge();
      for (int i = 0; i < N; i++) begin
        if (e_gnt0[i]) pend[i][0] = 1'b0;
        if (e_gnt1[i]) pend[i][1] = 1'b0;
      end
      toPosedge();
    end
    idleReq();
    repeat (4) runCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 32x16 data RAM between two requesters: port 0 is the processor load/store path, port 1 is the loader/debug path that preloads or inspects data memory.
- Arbitrates each access, drives the RAM address, data and write-enable, and returns read data with a valid strobe to the winning requester.
- Sits between the processor and the data RAM in the top level. Everything runs in one clock domain.

Parameters:
AW, 5, RAM address width
DW, 16, data width
RD_LAT, 1, RAM read latency in cycles: mem_dout is valid RD_LAT cycles after the address edge (legal 1..2)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 always wins)

Ports:
Clock  in  1  single system clock, rising edge
Reset  in  1  synchronous, active-high reset
req0  in  1  port 0 access request, held until gnt0
we0  in  1  port 0 write (1) / read (0)
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 grant, one-cycle pulse
rvalid0  out  1  port 0 read data valid, one-cycle pulse
req1, we1, addr1, wdata1, gnt1, rvalid1  as port 0, for port 1
rdata  out  DW  registered read data, shared by both ports, qualified by rvalidX
mem_addr  out  AW  RAM address
mem_din  out  DW  RAM write data
mem_we  out  1  RAM write enable
mem_dout  in  DW  RAM read data
busy  out  1  high while a read is outstanding (state != IDLE)

Behaviour:
- Reset: state=IDLE; gnt0/1=0; rvalid0/1=0; rdata=0; mem_we=0; mem_addr=0; mem_din=0; rr pointer=port 0 favoured; wait counter=0. Reset mid-read aborts the read and no rvalid is issued.
- States: IDLE, RDWAIT.
- IDLE, no req: no grant, mem_we=0, mem_addr/mem_din hold their last granted values (registered hold).
- IDLE, any req: the winner is chosen combinationally in cycle T.
  - gntX=1 in T.
  - mem_addr=addrX, mem_din=wdataX, mem_we=weX, all combinational from the winner in T.
  - Hold registers capture the winner's values at the end of T.
- Write grant: completes at the edge ending T. Stay in IDLE, so back-to-back writes can be granted every cycle.
- Read grant: go to RDWAIT, load counter=RD_LAT, latch the owner id.
- RDWAIT:
  - No grants. gnt0/1=0 and mem_we=0 regardless of req.
  - Counter decrements each cycle.
  - In the cycle where mem_dout is valid (cycle T+RD_LAT), rdata<=mem_dout at its end.
  - rvalid[owner]=1 for exactly cycle T+RD_LAT+1, and the state returns to IDLE in that same cycle.
  - A new grant is allowed in the rvalid cycle.
- Read-to-grant spacing: RD_LAT+1 cycles.
- rdata holds its value until the next read completes.
- Round-robin (PRIO_MODE=0):
  - On simultaneous req0 and req1, the port that did not win last time wins. After reset, port 0 wins the first tie.
  - The pointer updates only on a grant.
  - A single requester always wins, regardless of the pointer.
- Fixed priority (PRIO_MODE=1): port 0 wins every tie. Port 1 may starve.
- Requester protocol:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - req still high in the cycle after gnt is a new request.
  - A request asserted during RDWAIT waits. A request dropped before its grant is simply never served; no error is raised.
- gnt0 and gnt1 are never high together. rvalid0 and rvalid1 are never high together. gnt is never asserted during RDWAIT.
- Address wrap: none. The address passes through unchanged, modulo 2^AW.

Test Plan:
1. Reset, then port 1 writes 0x1234 to addr 5 -> gnt1=1 in the same cycle, mem_we=1, mem_addr=5, mem_din=0x1234; busy stays 0.
2. Port 0 reads addr 5 with RD_LAT=1 after the write above -> gnt0 at T, busy=1 at T+1, rvalid0=1 with rdata=0x1234 at T+2; rvalid1 stays 0.
3. req0 and req1 held high continuously (writes, PRIO_MODE=0) -> grants alternate 0,1,0,1 every cycle. With PRIO_MODE=1 -> gnt0 every cycle, gnt1 never.
4. Port 0 read outstanding with RD_LAT=2 while port 1 requests a write -> gnt1 withheld at T+1 and T+2, granted at T+3 in the same cycle as rvalid0.
5. Reset asserted at T+1 of an outstanding read -> no rvalid afterwards; rdata=0, busy=0, mem_we=0; a tied request afterwards is granted to port 0.
6. Back-to-back writes from port 0 to addr 31, then addr 0 -> mem_addr=31 then 0; no wrap artefacts, one gnt0 per cycle.
